// File: rtl/mod100_count_checker_pkg.sv
// Shared types and helpers for the mod-100 counter bus checker.
//   chk_state_e : checker FSM states (HUNT, SYNC, LOCKED)
//   MODULUS_DEF : default count period
//   CW_DEF      : default count bus width
//   succ()      : successor of a count value with explicit wrap (no bus overflow)
package mod100_count_checker_pkg;

  localparam int unsigned MODULUS_DEF = 100;
  localparam int unsigned CW_DEF      = 7;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // Next value in the sequence; wraps at modulus-1 explicitly.
  function automatic int unsigned succ(input int unsigned v, input int unsigned modulus);
    return (v == modulus - 32'd1) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/mod100_count_checker_sat_counter.sv
// Saturating event counter: increments on inc_i, holds at all-ones.
//   clk, rst_n : clock, async active-low reset
//   inc_i      : count one event this cycle
//   value_o    : current count
module mod100_count_checker_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (inc_i && (value_q != {W{1'b1}})) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/mod100_count_checker.sv
// Receiving-end monitor for a mod-MODULUS counter bus. Locks onto the
// sequence after LOCK_CNT correct increments, then checks every sample
// against a predicted value; reports mismatch, out-of-range and wrap events.
//   clk, rst   : clock, async active-low reset
//   count_in   : counter value under check, sampled when count_vld=1
//   locked     : checker in LOCKED state
//   expected   : predicted next value (meaningful while locked)
//   err_pulse  : sequence mismatch while locked
//   range_err  : sample >= MODULUS (any state)
//   wrap_pulse : checked wrap MODULUS-1 -> 0 while locked
//   err_count, wrap_count : saturating event counts
// Build option: define MOD100_CHK_HOLD_OK_EN to accept a repeated value
// (counter held) in SYNC and LOCKED without error or state change.
module mod100_count_checker
  import mod100_count_checker_pkg::*;
#(
  parameter int unsigned MODULUS  = MODULUS_DEF,
  parameter int unsigned CW       = CW_DEF,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned WRAP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     count_in,
  input  logic              count_vld,
  output logic              locked,
  output logic [CW-1:0]     expected,
  output logic              err_pulse,
  output logic              range_err,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  chk_state_e    state_q, state_d;
  logic [CW-1:0] prev_q, prev_d;
  logic [CW-1:0] exp_q, exp_d;
  logic [3:0]    run_q, run_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          rng_q, rng_d;
  logic          wrap_q, wrap_d;

  logic [CW-1:0] succ_in;
  logic [CW-1:0] succ_prev;
  logic          in_range;
  logic          hold_ok;

  assign succ_in   = CW'(succ(32'(count_in), MODULUS));
  assign succ_prev = CW'(succ(32'(prev_q), MODULUS));
  assign in_range  = (32'(count_in) < MODULUS);

  // A repeated sample is only tolerated when the hold option is built in.
`ifdef MOD100_CHK_HOLD_OK_EN
  assign hold_ok = (count_in == prev_q);
`else
  assign hold_ok = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_HUNT;
      prev_q   <= '0;
      exp_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      rng_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      rng_q    <= rng_d;
      wrap_q   <= wrap_d;
    end
  end

  // Next-state and pulse logic; nothing moves unless count_vld is high.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    exp_d   = exp_q;
    run_d   = run_q;
    err_d   = 1'b0;
    rng_d   = 1'b0;
    wrap_d  = 1'b0;
    if (count_vld) begin
      if (!in_range) begin
        rng_d   = 1'b1;
        err_d   = (state_q == ST_LOCKED);
        state_d = ST_HUNT;
        run_d   = '0;
      end else begin
        unique case (state_q)
          ST_HUNT: begin
            prev_d  = count_in;
            run_d   = '0;
            state_d = ST_SYNC;
          end
          ST_SYNC: begin
            if (!hold_ok) begin
              prev_d = count_in;
              if (count_in == succ_prev) begin
                run_d = run_q + 4'd1;
                if ((32'(run_q) + 32'd1) >= LOCK_CNT) begin
                  state_d = ST_LOCKED;
                  exp_d   = succ_in;
                end
              end else begin
                run_d = '0;
              end
            end
          end
          ST_LOCKED: begin
            if (!hold_ok) begin
              if (count_in == exp_q) begin
                exp_d  = succ_in;
                prev_d = count_in;
                wrap_d = (count_in == '0);
              end else begin
                err_d   = 1'b1;
                state_d = ST_HUNT;
              end
            end
          end
          default: state_d = ST_HUNT;
        endcase
      end
    end
    locked_d = (state_d == ST_LOCKED);
  end

  mod100_count_checker_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (err_d),
    .value_o (err_count)
  );

  mod100_count_checker_sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (wrap_d),
    .value_o (wrap_count)
  );

  assign locked     = locked_q;
  assign expected   = exp_q;
  assign err_pulse  = err_q;
  assign range_err  = rng_q;
  assign wrap_pulse = wrap_q;

endmodule
